// File: rtl/uart2wb_burst.sv
// uart2wb_burst: UART (8N1) to Wishbone burst bridge.
// A host frame is a command byte (bit7 = write, bits6:0 = LEN-1), then the
// address MSB-first, then LEN data bytes for a write. Each byte becomes one
// Wishbone access at an incrementing address. The reply is the read bytes
// (reads only) followed by one status byte: 00 ok, 01 err, 02 rty, 03 timeout.
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   uart_rxd, uart_txd   UART lines (idle high)
//   cyc_o, stb_o, adr_o, dat_o, we_o   Wishbone master request
//   ack_i, err_i, rty_i, dat_i         Wishbone master response
module uart2wb_burst #(
    parameter int CLKS_PER_BIT   = 16,
    parameter int ADDR_WIDTH     = 23,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  uart_rxd,
    output logic                  uart_txd,
    output logic                  cyc_o,
    output logic                  stb_o,
    output logic [ADDR_WIDTH-1:0] adr_o,
    output logic [7:0]            dat_o,
    output logic                  we_o,
    input  logic                  ack_i,
    input  logic                  err_i,
    input  logic                  rty_i,
    input  logic [7:0]            dat_i
);
    localparam int ADDR_BYTES = (ADDR_WIDTH + 7) / 8;
    localparam int HALF_BIT   = CLKS_PER_BIT / 2;

    localparam logic [7:0] ST_OK  = 8'h00;
    localparam logic [7:0] ST_ERR = 8'h01;
    localparam logic [7:0] ST_RTY = 8'h02;
    localparam logic [7:0] ST_TMO = 8'h03;

    typedef enum logic [2:0] {RX_CMD, RX_ADDR, RX_DATA, WB, TX_DATA, TX_STATUS} state_t;
    typedef enum logic [1:0] {RS_IDLE, RS_START, RS_DATA, RS_STOP} rx_state_t;

    state_t      state;

    logic [1:0]  rx_sync;
    logic        rx_prev;
    rx_state_t   rx_state;
    logic [7:0]  rx_cnt;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_shift;
    logic        rx_valid;
    logic        rx_ferr;
    logic        rx_en;

    logic        tx_busy;
    logic [7:0]  tx_cnt;
    logic [3:0]  tx_bit;
    logic [8:0]  tx_shift;
    logic        tx_last;
    logic        tx_load;

    logic        tx_req;
    logic [7:0]  tx_byte;
    logic [6:0]  remain;
    logic [2:0]  abyte_cnt;
    logic [7:0]  status;
    logic [15:0] tmo_cnt;
    logic        wb_term;
    logic [7:0]  wb_code;

    // Half-duplex: the receiver only listens while a frame is being collected.
    assign rx_en = (state == RX_CMD) || (state == RX_ADDR) || (state == RX_DATA);

    // Termination decode with ack > err > rty > timeout priority.
    always_comb begin
        // NOTE: every output gets a default first, so no path infers a latch.
        wb_term = 1'b0;
        wb_code = ST_TMO;
        if (cyc_o) begin
            if (ack_i) begin
                wb_term = 1'b1;
                wb_code = ST_OK;
            end else if (err_i) begin
                wb_term = 1'b1;
                wb_code = ST_ERR;
            end else if (rty_i) begin
                wb_term = 1'b1;
                wb_code = ST_RTY;
            end else if (tmo_cnt == 16'(TIMEOUT_CYCLES - 1)) begin
                wb_term = 1'b1;
            end
        end
    end

    // Receiver: rx_valid / rx_ferr are one-cycle pulses with the byte in rx_shift.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_sync  <= 2'b11;
            rx_prev  <= 1'b1;
            rx_state <= RS_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge value of its neighbours.
            rx_sync  <= {rx_sync[0], uart_rxd};
            rx_prev  <= rx_sync[1];
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
            if (!rx_en) begin
                rx_state <= RS_IDLE;
            end else begin
                case (rx_state)
                    RS_IDLE: begin
                        if (rx_prev && !rx_sync[1]) begin
                            rx_state <= RS_START;
                            rx_cnt   <= '0;
                        end
                    end
                    RS_START: begin
                        if (rx_cnt == 8'(HALF_BIT - 1)) begin
                            rx_cnt   <= '0;
                            rx_bit   <= '0;
                            // Line back high at mid start bit: a glitch, not a byte.
                            rx_state <= rx_sync[1] ? RS_IDLE : RS_DATA;
                        end else begin
                            rx_cnt <= rx_cnt + 8'd1;
                        end
                    end
                    RS_DATA: begin
                        if (rx_cnt == 8'(CLKS_PER_BIT - 1)) begin
                            rx_cnt   <= '0;
                            rx_shift <= {rx_sync[1], rx_shift[7:1]};
                            if (rx_bit == 3'd7) rx_state <= RS_STOP;
                            else                rx_bit   <= rx_bit + 3'd1;
                        end else begin
                            rx_cnt <= rx_cnt + 8'd1;
                        end
                    end
                    RS_STOP: begin
                        if (rx_cnt == 8'(CLKS_PER_BIT - 1)) begin
                            rx_state <= RS_IDLE;
                            rx_valid <= rx_sync[1];
                            rx_ferr  <= !rx_sync[1];
                        end else begin
                            rx_cnt <= rx_cnt + 8'd1;
                        end
                    end
                    default: rx_state <= RS_IDLE;
                endcase
            end
        end
    end

    // Transmitter: a pending byte is loaded on the last cycle of the previous
    // stop bit, so back-to-back bytes are separated by exactly one stop bit.
    assign tx_last = tx_busy && (tx_cnt == 8'(CLKS_PER_BIT - 1)) && (tx_bit == 4'd9);
    assign tx_load = tx_req && (!tx_busy || tx_last);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tx_busy  <= 1'b0;
            uart_txd <= 1'b1;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '1;
        end else if (tx_load) begin
            tx_busy  <= 1'b1;
            uart_txd <= 1'b0;
            tx_shift <= {1'b1, tx_byte};
            tx_cnt   <= '0;
            tx_bit   <= '0;
        end else if (tx_busy) begin
            if (tx_cnt == 8'(CLKS_PER_BIT - 1)) begin
                tx_cnt <= '0;
                if (tx_bit == 4'd9) begin
                    tx_busy  <= 1'b0;
                    uart_txd <= 1'b1;
                end else begin
                    uart_txd <= tx_shift[0];
                    tx_shift <= {1'b1, tx_shift[8:1]};
                    tx_bit   <= tx_bit + 4'd1;
                end
            end else begin
                tx_cnt <= tx_cnt + 8'd1;
            end
        end
    end

    // Frame sequencer. A read pipelines the next access behind the byte
    // currently being shifted out; after a failure no access is issued.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= RX_CMD;
            cyc_o     <= 1'b0;
            stb_o     <= 1'b0;
            adr_o     <= '0;
            dat_o     <= '0;
            we_o      <= 1'b0;
            tx_req    <= 1'b0;
            tx_byte   <= '0;
            remain    <= '0;
            abyte_cnt <= '0;
            status    <= ST_OK;
            tmo_cnt   <= '0;
        end else begin
            if (tx_load) tx_req <= 1'b0;
            case (state)
                RX_CMD: begin
                    if (rx_valid) begin
                        we_o      <= rx_shift[7];
                        remain    <= rx_shift[6:0];
                        status    <= ST_OK;
                        abyte_cnt <= '0;
                        state     <= RX_ADDR;
                    end
                end
                RX_ADDR: begin
                    if (rx_ferr) begin
                        state <= RX_CMD;
                    end else if (rx_valid) begin
                        // Shift in MSB-first; bits above ADDR_WIDTH fall off.
                        adr_o <= ADDR_WIDTH'({adr_o, rx_shift});
                        if (abyte_cnt == 3'(ADDR_BYTES - 1)) begin
                            if (we_o) begin
                                state <= RX_DATA;
                            end else begin
                                cyc_o   <= 1'b1;
                                stb_o   <= 1'b1;
                                tmo_cnt <= '0;
                                state   <= WB;
                            end
                        end else begin
                            abyte_cnt <= abyte_cnt + 3'd1;
                        end
                    end
                end
                RX_DATA: begin
                    if (rx_ferr) begin
                        state <= RX_CMD;
                    end else if (rx_valid) begin
                        if (status != ST_OK) begin
                            // Failed frame: swallow the remaining data bytes.
                            if (remain == 7'd0) begin
                                tx_req  <= 1'b1;
                                tx_byte <= status;
                                state   <= TX_STATUS;
                            end else begin
                                remain <= remain - 7'd1;
                            end
                        end else begin
                            dat_o   <= rx_shift;
                            cyc_o   <= 1'b1;
                            stb_o   <= 1'b1;
                            tmo_cnt <= '0;
                            state   <= WB;
                        end
                    end
                end
                WB: begin
                    if (wb_term) begin
                        cyc_o  <= 1'b0;
                        stb_o  <= 1'b0;
                        adr_o  <= adr_o + ADDR_WIDTH'(1);
                        status <= wb_code;
                        if (!we_o) begin
                            tx_req  <= 1'b1;
                            tx_byte <= (wb_code == ST_OK) ? dat_i : 8'h00;
                            state   <= TX_DATA;
                        end else if (remain == 7'd0) begin
                            tx_req  <= 1'b1;
                            tx_byte <= wb_code;
                            state   <= TX_STATUS;
                        end else begin
                            remain <= remain - 7'd1;
                            state  <= RX_DATA;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                TX_DATA: begin
                    if (tx_load) begin
                        if (remain == 7'd0) begin
                            tx_req  <= 1'b1;
                            tx_byte <= status;
                            state   <= TX_STATUS;
                        end else begin
                            remain <= remain - 7'd1;
                            if (status != ST_OK) begin
                                tx_req  <= 1'b1;
                                tx_byte <= 8'h00;
                            end else begin
                                cyc_o   <= 1'b1;
                                stb_o   <= 1'b1;
                                tmo_cnt <= '0;
                                state   <= WB;
                            end
                        end
                    end
                end
                TX_STATUS: begin
                    // Back to listening only once the status stop bit is done.
                    if (!tx_req && !tx_busy) state <= RX_CMD;
                end
                default: state <= RX_CMD;
            endcase
        end
    end

endmodule

// File: tb/tb_uart2wb_burst.sv
// tb_uart2wb_burst: directed bench for uart2wb_burst (16 clocks/bit, 23-bit
// address, 255-cycle timeout). A host UART driver sends frames, a Wishbone
// slave model answers with a per-access response script, and a UART monitor
// collects reply bytes and their start times.
`timescale 1ns/1ps
module tb_uart2wb_burst;
    localparam int CPB = 16;
    localparam int AW  = 23;
    localparam int TMO = 255;
    localparam int PERIOD = 10;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic          uart_rxd = 1'b1;
    logic          uart_txd;
    logic          cyc_o, stb_o, we_o;
    logic [AW-1:0] adr_o;
    logic [7:0]    dat_o;
    logic          ack_i = 1'b0, err_i = 1'b0, rty_i = 1'b0;
    logic [7:0]    dat_i = 8'hEE;

    always #(PERIOD/2) clk = ~clk;

    uart2wb_burst #(
        .CLKS_PER_BIT  (CPB),
        .ADDR_WIDTH    (AW),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_i   (clk),
        .rst_ni  (rst_ni),
        .uart_rxd(uart_rxd),
        .uart_txd(uart_txd),
        .cyc_o   (cyc_o),
        .stb_o   (stb_o),
        .adr_o   (adr_o),
        .dat_o   (dat_o),
        .we_o    (we_o),
        .ack_i   (ack_i),
        .err_i   (err_i),
        .rty_i   (rty_i),
        .dat_i   (dat_i)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Slave script, indexed relative to the first access of the current test:
    // 0 ack, 1 err, 2 rty, 3 silent, 4 ack+err+rty, 5 err+rty.
    int            resp [256];
    logic [7:0]    rd_data [256];
    int            acc_base = 0;

    int            acc_count = 0;
    logic [AW-1:0] acc_adr [256];
    logic          acc_we  [256];
    logic [7:0]    acc_dat [256];
    int            acc_len [256];
    int            stable_viol = 0;
    int            wait_cnt = 0;
    logic          cyc_prev = 1'b0;

    always @(negedge clk) begin
        ack_i = 1'b0;
        err_i = 1'b0;
        rty_i = 1'b0;
        dat_i = 8'hEE;
        if (!rst_ni) begin
            cyc_prev = 1'b0;
            wait_cnt = 0;
        end else begin
            if (cyc_o && stb_o) begin
                if (!cyc_prev) begin
                    if (acc_count < 256) begin
                        acc_adr[acc_count] = adr_o;
                        acc_we[acc_count]  = we_o;
                        acc_dat[acc_count] = dat_o;
                        acc_len[acc_count] = 0;
                    end
                    acc_count++;
                    wait_cnt = 0;
                end else if (acc_count <= 256) begin
                    if (adr_o !== acc_adr[acc_count-1] || we_o !== acc_we[acc_count-1] ||
                        dat_o !== acc_dat[acc_count-1])
                        stable_viol++;
                end
                if (acc_count <= 256) acc_len[acc_count-1]++;
                wait_cnt++;
                if (wait_cnt == 2 && (acc_count - 1 - acc_base) < 256) begin
                    case (resp[acc_count-1-acc_base])
                        0: ack_i = 1'b1;
                        1: err_i = 1'b1;
                        2: rty_i = 1'b1;
                        4: begin ack_i = 1'b1; err_i = 1'b1; rty_i = 1'b1; end
                        5: begin err_i = 1'b1; rty_i = 1'b1; end
                        default: ;
                    endcase
                    dat_i = rd_data[acc_count-1-acc_base];
                end
            end
            cyc_prev = cyc_o;
        end
    end

    // UART monitor on uart_txd.
    logic [7:0] tx_q [$];
    time        tx_t [$];
    int         tx_falls = 0;
    int         tx_stop_bad = 0;

    always @(negedge uart_txd) if (rst_ni) tx_falls++;

    initial begin : tx_monitor
        logic [7:0] b;
        time        t0;
        forever begin
            @(negedge uart_txd);
            t0 = $time;
            repeat (CPB/2) @(negedge clk);
            if (uart_txd !== 1'b0) continue;
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge clk);
                b[i] = uart_txd;
            end
            repeat (CPB) @(negedge clk);
            if (uart_txd !== 1'b1) tx_stop_bad++;
            tx_q.push_back(b);
            tx_t.push_back(t0);
        end
    end

    int tx_base = 0;
    int falls_base = 0;
    logic [7:0] frame [$];

    task automatic begin_test();
        acc_base   = acc_count;
        tx_base    = tx_q.size();
        falls_base = tx_falls;
        for (int i = 0; i < 256; i++) begin
            resp[i]    = 0;
            rd_data[i] = 8'h00;
        end
    endtask

    function automatic logic [7:0] txb(input int i);
        if (tx_base + i < tx_q.size()) return tx_q[tx_base + i];
        return 8'hxx;
    endfunction

    function automatic int tx_gap(input int i);
        if (tx_base + i < tx_t.size())
            return int'((tx_t[tx_base + i] - tx_t[tx_base + i - 1]) / PERIOD);
        return -1;
    endfunction

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        uart_rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rxd = stop_bit;
        repeat (CPB - 1) @(negedge clk);
        uart_rxd = 1'b1;
    endtask

    task automatic send_frame();
        foreach (frame[i]) send_byte(frame[i], 1'b1);
    endtask

    task automatic wait_tx(input string tag, input int n, input int budget);
        int c = 0;
        while ((tx_q.size() - tx_base) < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        repeat (3*CPB) @(negedge clk);
        check({tag, "_txcount"}, 32'(tx_q.size() - tx_base), 32'(n));
    endtask

    initial begin : main
        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_cyc", 32'(cyc_o), 0);
        check("rst_stb", 32'(stb_o), 0);
        check("rst_we",  32'(we_o), 0);
        check("rst_adr", 32'(adr_o), 0);
        check("rst_dat", 32'(dat_o), 0);
        check("rst_txd", 32'(uart_txd), 1);
        @(negedge clk);
        rst_ni = 1'b1;
        repeat (4*CPB) @(negedge clk);

        // Single write
        begin_test();
        frame = '{8'h80, 8'h01, 8'h23, 8'h45, 8'hA5};
        send_frame();
        wait_tx("wr1", 1, 1000);
        check("wr1_status", 32'(txb(0)), 32'h00);
        check("wr1_nacc",   32'(acc_count - acc_base), 1);
        check("wr1_adr",    32'(acc_adr[acc_base]), 32'h012345);
        check("wr1_we",     32'(acc_we[acc_base]), 1);
        check("wr1_dat",    32'(acc_dat[acc_base]), 32'hA5);
        check("wr1_len",    32'(acc_len[acc_base]), 2);

        // Burst read with address wrap, replies back to back
        begin_test();
        rd_data[0] = 8'h11; rd_data[1] = 8'h22; rd_data[2] = 8'h33; rd_data[3] = 8'h44;
        frame = '{8'h03, 8'h7F, 8'hFF, 8'hFE};
        send_frame();
        wait_tx("rd4", 5, 2000);
        check("rd4_nacc", 32'(acc_count - acc_base), 4);
        check("rd4_adr0", 32'(acc_adr[acc_base]),   32'h7FFFFE);
        check("rd4_adr1", 32'(acc_adr[acc_base+1]), 32'h7FFFFF);
        check("rd4_adr2", 32'(acc_adr[acc_base+2]), 32'h000000);
        check("rd4_adr3", 32'(acc_adr[acc_base+3]), 32'h000001);
        check("rd4_we",   32'(acc_we[acc_base]), 0);
        check("rd4_b0", 32'(txb(0)), 32'h11);
        check("rd4_b1", 32'(txb(1)), 32'h22);
        check("rd4_b2", 32'(txb(2)), 32'h33);
        check("rd4_b3", 32'(txb(3)), 32'h44);
        check("rd4_st", 32'(txb(4)), 32'h00);
        for (int i = 1; i < 5; i++) check($sformatf("rd4_gap%0d", i), 32'(tx_gap(i)), 32'(10*CPB));

        // Error on second access of a 3-byte write
        begin_test();
        resp[1] = 1;
        frame = '{8'h82, 8'h00, 8'h01, 8'h00, 8'hD1, 8'hD2, 8'hD3};
        send_frame();
        wait_tx("werr", 1, 1000);
        check("werr_nacc",   32'(acc_count - acc_base), 2);
        check("werr_adr1",   32'(acc_adr[acc_base+1]), 32'h000101);
        check("werr_dat1",   32'(acc_dat[acc_base+1]), 32'hD2);
        check("werr_status", 32'(txb(0)), 32'h01);

        // Timeout on a 2-byte read with a silent slave
        begin_test();
        resp[0] = 3;
        frame = '{8'h01, 8'h00, 8'h00, 8'h40};
        send_frame();
        wait_tx("tmo", 3, 1500);
        check("tmo_nacc", 32'(acc_count - acc_base), 1);
        check("tmo_len",  32'(acc_len[acc_base]), 32'(TMO));
        check("tmo_b0",   32'(txb(0)), 32'h00);
        check("tmo_b1",   32'(txb(1)), 32'h00);
        check("tmo_st",   32'(txb(2)), 32'h03);

        // Framing error on a command byte, then a good frame
        begin_test();
        send_byte(8'h80, 1'b0);
        repeat (20*CPB) @(negedge clk);
        check("ferr_nacc",  32'(acc_count - acc_base), 0);
        check("ferr_falls", 32'(tx_falls - falls_base), 0);
        frame = '{8'h80, 8'h00, 8'h00, 8'h10, 8'h5A};
        send_frame();
        wait_tx("ferr_ok", 1, 1000);
        check("ferr_ok_nacc",   32'(acc_count - acc_base), 1);
        check("ferr_ok_adr",    32'(acc_adr[acc_base]), 32'h000010);
        check("ferr_ok_dat",    32'(acc_dat[acc_base]), 32'h5A);
        check("ferr_ok_status", 32'(txb(0)), 32'h00);

        // Priority: ack beats err/rty, err beats rty
        begin_test();
        resp[0] = 4; rd_data[0] = 8'h6C;
        resp[1] = 5;
        frame = '{8'h01, 8'h00, 8'h00, 8'h20};
        send_frame();
        wait_tx("pri", 3, 1500);
        check("pri_nacc", 32'(acc_count - acc_base), 2);
        check("pri_b0",   32'(txb(0)), 32'h6C);
        check("pri_b1",   32'(txb(1)), 32'h00);
        check("pri_st",   32'(txb(2)), 32'h01);

        // Retry on first access of a 2-byte write
        begin_test();
        resp[0] = 2;
        frame = '{8'h81, 8'h00, 8'h00, 8'h30, 8'h01, 8'h02};
        send_frame();
        wait_tx("rty", 1, 1000);
        check("rty_nacc",   32'(acc_count - acc_base), 1);
        check("rty_status", 32'(txb(0)), 32'h02);

        // Asynchronous reset in the middle of an access
        begin_test();
        resp[0] = 3;
        frame = '{8'h00, 8'h00, 8'h00, 8'h08};
        send_frame();
        begin
            int c = 0;
            while (!cyc_o && c < 500) begin
                @(negedge clk);
                c++;
            end
        end
        check("arst_cyc_seen", 32'(cyc_o), 1);
        repeat (10) @(negedge clk);
        #2 rst_ni = 1'b0;
        #1;
        check("arst_cyc", 32'(cyc_o), 0);
        check("arst_stb", 32'(stb_o), 0);
        check("arst_txd", 32'(uart_txd), 1);
        check("arst_adr", 32'(adr_o), 0);
        repeat (3) @(negedge clk);
        rst_ni = 1'b1;
        repeat (30*CPB) @(negedge clk);
        check("arst_nacc",  32'(acc_count - acc_base), 1);
        check("arst_falls", 32'(tx_falls - falls_base), 0);
        begin_test();
        frame = '{8'h80, 8'h00, 8'h00, 8'h08, 8'h77};
        send_frame();
        wait_tx("arst_next", 1, 1000);
        check("arst_next_nacc",   32'(acc_count - acc_base), 1);
        check("arst_next_dat",    32'(acc_dat[acc_base]), 32'h77);
        check("arst_next_status", 32'(txb(0)), 32'h00);

        check("wb_stable",   32'(stable_viol), 0);
        check("tx_stop_bits", 32'(tx_stop_bad), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
